// File: rtl/nibble_streamer.sv
// Word-to-nibble serializer with a small input FIFO, driving a read-strobed nibble bus.
// Optional checksum nibble per word when NIBBLE_STREAMER_CHECKSUM_EN is defined.
module nibble_streamer #(
  parameter int NIBBLES = 2,
  parameter int GAP     = 1,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic [3:0]             nibble,
  output logic                   read,
  output logic                   busy
);

  localparam int DATA_W = 4 * NIBBLES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int NI_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [NI_W-1:0]  NIB_LAST = NI_W'(NIBBLES - 1);

`ifdef NIBBLE_STREAMER_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_GAP, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_GAP} state_t;
`endif

  state_t state, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] sreg;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [NI_W-1:0]   nib_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [3:0]        nibble_q;
  logic              read_q;
  logic              busy_q;

  logic push, pop, adv, nib_done, last_nib;

`ifdef NIBBLE_STREAMER_CHECKSUM_EN
  logic       csum_load;
  logic       csum_phase;
  logic [3:0] acc;
`endif

  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign last_nib = (nib_idx == NIB_LAST);

  assign nibble = nibble_q;
  assign read   = read_q;
  assign busy   = busy_q;

  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    adv      = 1'b0;
    nib_done = 1'b0;
`ifdef NIBBLE_STREAMER_CHECKSUM_EN
    csum_load = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: begin
        if (GAP == 0) nib_done = 1'b1;
        else          state_d  = ST_GAP;
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) nib_done = 1'b1;
      end
`ifdef NIBBLE_STREAMER_CHECKSUM_EN
      ST_CSUM:   state_d = ST_STROBE;
`endif
      default:   state_d = ST_IDLE;
    endcase

    // A finished nibble either advances within the word or closes it out.
    if (nib_done) begin
`ifdef NIBBLE_STREAMER_CHECKSUM_EN
      if (csum_phase) begin
        state_d = ST_IDLE;
      end else if (!last_nib) begin
        adv     = 1'b1;
        state_d = ST_SETUP;
      end else begin
        csum_load = 1'b1;
        state_d   = ST_CSUM;
      end
`else
      if (!last_nib) begin
        adv     = 1'b1;
        state_d = ST_SETUP;
      end else begin
        state_d = ST_IDLE;
      end
`endif
    end
  end

  // FIFO storage and word shift register carry data only, so they are not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
    if (pop)      sreg <= head >> 4;
    else if (adv) sreg <= sreg >> 4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      nib_idx  <= '0;
      gap_cnt  <= '0;
      nibble_q <= '0;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
      if (pop) begin
        nib_idx  <= '0;
        nibble_q <= head[3:0];
      end else if (adv) begin
        nib_idx  <= nib_idx + NI_W'(1);
        nibble_q <= sreg[3:0];
      end
`ifdef NIBBLE_STREAMER_CHECKSUM_EN
      else if (csum_load) begin
        nibble_q <= acc;
      end
`endif
      read_q <= (state_d == ST_STROBE);
      busy_q <= (state != ST_IDLE) || (count != '0);
    end
  end

`ifdef NIBBLE_STREAMER_CHECKSUM_EN
  // Running mod-16 sum of the nibbles placed on the bus for the current word.
  always_ff @(posedge clk) begin
    if (reset) begin
      csum_phase <= 1'b0;
      acc        <= '0;
    end else begin
      if (pop) begin
        csum_phase <= 1'b0;
        acc        <= head[3:0];
      end else begin
        if (adv)                     acc <= acc + sreg[3:0];
        else if (state == ST_IDLE)   acc <= '0;
        if (csum_load) csum_phase <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nibble_streamer.sv
// Directed bench for nibble_streamer at default parameters (NIBBLES=2, GAP=1, DEPTH=4).
module tb_nibble_streamer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] nibble;
  logic       read;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [3:0] strb_nib [$];
  int         strb_cyc [$];

  nibble_streamer #(.NIBBLES(2), .GAP(1), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .nibble   (nibble),
    .read     (read),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent rising edge; strobes logged with that index.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (read === 1'b1) begin
      strb_nib.push_back(nibble);
      strb_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    strb_nib.delete();
    strb_cyc.delete();
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while (busy !== 1'b0 && i < limit) begin
      tick();
      i++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (nibble !== 4'h0) begin n_bad++; $display("FAIL rst_nibble: got %h need 0", nibble); end
    n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL rst_read: got %b need 0", read); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
    clear_log();
    repeat (20) tick();
    n_cmp++; if (strb_nib.size() !== 0) begin n_bad++; $display("FAIL rst_no_strobe: got %0d strobes need 0", strb_nib.size()); end
  endtask

  task automatic test_single_word();
    int n0;
    logic pre;
    clear_log();
    in_data = 8'hA5;
    in_valid = 1'b1;
    pre = in_ready;
    tick();
    in_valid = 1'b0;
    n0 = cyc;
    n_cmp++; if (pre !== 1'b1) begin n_bad++; $display("FAIL single_accept: in_ready %b need 1", pre); end
    tick();
    n_cmp++; if (nibble !== 4'h5) begin n_bad++; $display("FAIL single_first_nibble: got %h need 5", nibble); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_high: got %b need 1", busy); end
    repeat (11) tick();
    n_cmp++; if (strb_nib.size() !== 2) begin n_bad++; $display("FAIL single_count: got %0d strobes need 2", strb_nib.size()); end
    if (strb_nib.size() >= 2) begin
      n_cmp++; if (strb_nib[0] !== 4'h5) begin n_bad++; $display("FAIL single_nib0: got %h need 5", strb_nib[0]); end
      n_cmp++; if (strb_nib[1] !== 4'hA) begin n_bad++; $display("FAIL single_nib1: got %h need a", strb_nib[1]); end
      n_cmp++; if (strb_cyc[0] !== n0 + 2) begin n_bad++; $display("FAIL single_t0: got edge %0d need %0d", strb_cyc[0], n0 + 2); end
      n_cmp++; if (strb_cyc[1] !== n0 + 5) begin n_bad++; $display("FAIL single_t1: got edge %0d need %0d", strb_cyc[1], n0 + 5); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_low: got %b need 0", busy); end
  endtask

  task automatic test_back_to_back();
    int idx;
    int drop_at;
    logic pre;
    logic [3:0] exp_n;
    clear_log();
    idx = 0;
    drop_at = -1;
    in_data = 8'h01;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && idx < 6; i++) begin
      pre = in_ready;
      tick();
      if (pre === 1'b1) begin
        idx++;
        if (idx == 6) in_valid = 1'b0;
        else          in_data  = 8'(idx + 1);
      end
      if (drop_at < 0 && in_ready !== 1'b1) drop_at = idx;
    end
    in_valid = 1'b0;
    n_cmp++; if (idx !== 6) begin n_bad++; $display("FAIL b2b_pushed: got %0d words need 6", idx); end
    n_cmp++; if (drop_at !== 5) begin n_bad++; $display("FAIL b2b_fill: got %0d pushes before in_ready drop need 5", drop_at); end
    wait_idle(200);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: busy %b need 0", busy); end
    n_cmp++; if (strb_nib.size() !== 12) begin n_bad++; $display("FAIL b2b_count: got %0d strobes need 12", strb_nib.size()); end
    if (strb_nib.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        exp_n = (k % 2 == 0) ? 4'(k / 2 + 1) : 4'h0;
        n_cmp++;
        if (strb_nib[k] !== exp_n) begin n_bad++; $display("FAIL b2b_nib[%0d]: got %h need %h", k, strb_nib[k], exp_n); end
        if (k > 0) begin
          n_cmp++;
          if (strb_cyc[k] - strb_cyc[k-1] !== ((k % 2 == 1) ? 3 : 4)) begin
            n_bad++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles need %0d", k, strb_cyc[k] - strb_cyc[k-1], (k % 2 == 1) ? 3 : 4);
          end
        end
      end
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] w [14];
    int n0;
    int idx;
    logic pre;
    logic [3:0] exp_n;
    for (int k = 0; k < 14; k++) w[k] = {4'((k + 3) & 15), 4'(k & 15)};
    clear_log();
    in_valid = 1'b1;
    in_data = w[0];
    pre = in_ready;
    tick();
    n0 = cyc;
    n_cmp++; if (pre !== 1'b1) begin n_bad++; $display("FAIL pp_accept0: in_ready %b need 1", pre); end
    in_data = w[1];
    tick();
    in_data = w[2];
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    // Next edge is the IDLE pop of w[1] with two words queued; push w[3] on it.
    in_valid = 1'b1;
    in_data = w[3];
    tick();
    n_cmp++; if (nibble !== w[1][3:0]) begin n_bad++; $display("FAIL pp_pop_edge: nibble %h need %h at edge %0d", nibble, w[1][3:0], n0 + 8); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL pp_count2: in_ready %b need 1", in_ready); end
    in_data = w[4];
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL pp_count3: in_ready %b need 1", in_ready); end
    in_data = w[5];
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL pp_count4: in_ready %b need 0", in_ready); end
    idx = 6;
    in_data = w[6];
    for (int i = 0; i < 300 && idx < 14; i++) begin
      pre = in_ready;
      tick();
      if (pre === 1'b1) begin
        idx++;
        if (idx == 14) in_valid = 1'b0;
        else           in_data  = w[idx];
      end
    end
    in_valid = 1'b0;
    n_cmp++; if (idx !== 14) begin n_bad++; $display("FAIL pp_pushed: got %0d words need 14", idx); end
    wait_idle(300);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pp_idle: busy %b need 0", busy); end
    n_cmp++; if (strb_nib.size() !== 28) begin n_bad++; $display("FAIL pp_count: got %0d strobes need 28", strb_nib.size()); end
    if (strb_nib.size() == 28) begin
      for (int k = 0; k < 28; k++) begin
        exp_n = (k % 2 == 0) ? w[k/2][3:0] : w[k/2][7:4];
        n_cmp++;
        if (strb_nib[k] !== exp_n) begin n_bad++; $display("FAIL pp_order[%0d]: got %h need %h", k, strb_nib[k], exp_n); end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    int n1;
    clear_log();
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    n_cmp++; if (read !== 1'b1 || nibble !== 4'hC) begin n_bad++; $display("FAIL mid_first_strobe: read %b nibble %h need 1 c", read, nibble); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (nibble !== 4'h0) begin n_bad++; $display("FAIL mid_rst_nibble: got %h need 0", nibble); end
    n_cmp++; if (read !== 1'b0) begin n_bad++; $display("FAIL mid_rst_read: got %b need 0", read); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b need 0", busy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b need 1", in_ready); end
    repeat (20) tick();
    n_cmp++; if (strb_nib.size() !== 1) begin n_bad++; $display("FAIL mid_abandon: got %0d strobes need 1", strb_nib.size()); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_flushed: busy %b need 0", busy); end
    clear_log();
    in_valid = 1'b1;
    in_data = 8'h12;
    tick();
    n1 = cyc;
    in_valid = 1'b0;
    repeat (10) tick();
    n_cmp++; if (strb_nib.size() !== 2) begin n_bad++; $display("FAIL mid_after_count: got %0d strobes need 2", strb_nib.size()); end
    if (strb_nib.size() == 2) begin
      n_cmp++; if (strb_nib[0] !== 4'h2 || strb_cyc[0] !== n1 + 2) begin n_bad++; $display("FAIL mid_after_nib0: got %h@%0d need 2@%0d", strb_nib[0], strb_cyc[0], n1 + 2); end
      n_cmp++; if (strb_nib[1] !== 4'h1 || strb_cyc[1] !== n1 + 5) begin n_bad++; $display("FAIL mid_after_nib1: got %h@%0d need 1@%0d", strb_nib[1], strb_cyc[1], n1 + 5); end
    end
  endtask

`ifdef NIBBLE_STREAMER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] words [2];
    logic [3:0] exp [2][3];
    words[0] = 8'hA5;
    words[1] = 8'hFF;
    exp[0][0] = 4'h5; exp[0][1] = 4'hA; exp[0][2] = 4'hF;
    exp[1][0] = 4'hF; exp[1][1] = 4'hF; exp[1][2] = 4'hE;
    for (int t = 0; t < 2; t++) begin
      wait_idle(50);
      clear_log();
      in_valid = 1'b1;
      in_data = words[t];
      tick();
      in_valid = 1'b0;
      repeat (15) tick();
      n_cmp++; if (strb_nib.size() !== 3) begin n_bad++; $display("FAIL csum_count[%0d]: got %0d strobes need 3", t, strb_nib.size()); end
      if (strb_nib.size() == 3) begin
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if (strb_nib[k] !== exp[t][k]) begin n_bad++; $display("FAIL csum_nib[%0d][%0d]: got %h need %h", t, k, strb_nib[k], exp[t][k]); end
        end
        n_cmp++; if (strb_cyc[2] - strb_cyc[1] !== 3) begin n_bad++; $display("FAIL csum_spacing[%0d]: got %0d need 3", t, strb_cyc[2] - strb_cyc[1]); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef NIBBLE_STREAMER_CHECKSUM_EN
    test_checksum();
`else
    test_single_word();
    wait_idle(100);
    test_back_to_back();
    wait_idle(100);
    test_push_pop();
    wait_idle(100);
    test_reset_mid_word();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
